// File: rtl/trng_pkg.sv
// trng_pkg: default parameters and health-state enum shared by the TRNG health FIFO
package trng_pkg;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_WARMUP = 16;
  localparam int DEF_RCT_CUTOFF = 4;
  localparam int DEF_APT_WINDOW = 64;
  localparam int DEF_APT_CUTOFF = 13;
  typedef enum logic [1:0] {S_WARMUP, S_RUN, S_ALARM} health_state_t;
endpackage

// File: rtl/trng_byte_fifo.sv
// trng_byte_fifo: first-word-fall-through byte FIFO (clk, reset, push, pop, flush, din -> dout, count, full, empty)
module trng_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    do_push = push && (!full || pop);
    do_pop = pop && !empty;
    dout = mem[rptr];
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= do_push ? wptr + AW'(1) : wptr;
      rptr <= do_pop ? rptr + AW'(1) : rptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= din;
  end
endmodule

// File: rtl/trng_health_fifo.sv
// trng_health_fifo: RCT/APT health-tested byte FIFO (clk, reset, in_data/in_valid -> out_data/out_valid/out_ready, alarm, alarm_clr, fill_level)
module trng_health_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WARMUP = DEF_WARMUP,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int APT_WINDOW = DEF_APT_WINDOW,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   alarm,
  input  logic                   alarm_clr,
  output logic [$clog2(DEPTH):0] fill_level
);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int MW = $clog2(APT_CUTOFF + 1);
  localparam int WW = $clog2(APT_WINDOW);
  localparam int CW = $clog2(WARMUP + 1);
  health_state_t state, state_next;
  logic [7:0] prev_byte, ref_byte;
  logic [RW-1:0] run_cnt, run_next;
  logic [MW-1:0] match_cnt, match_next;
  logic [WW-1:0] win_cnt;
  logic [CW-1:0] warm_cnt;
  logic accept, win_start, rct_fail, apt_fail, fail;
  logic push, pop, flush, full, empty;
  always_comb begin
    accept = in_valid && state != S_ALARM;
    win_start = win_cnt == '0;
    run_next = in_data == prev_byte ? run_cnt + RW'(1) : RW'(1);
    match_next = win_start ? MW'(1) : in_data == ref_byte ? match_cnt + MW'(1) : match_cnt;
    rct_fail = run_next >= RW'(RCT_CUTOFF);
    apt_fail = match_next >= MW'(APT_CUTOFF);
    fail = accept && (rct_fail || apt_fail);
  end
  always_ff @(posedge clk) begin
    if (reset) state <= S_WARMUP;
    else state <= state_next;
  end
  always_comb begin
    state_next = state == S_ALARM ? (alarm_clr ? S_WARMUP : S_ALARM) :
                 fail ? S_ALARM :
                 (state == S_WARMUP && accept && warm_cnt == CW'(WARMUP - 1)) ? S_RUN : state;
  end
  always_comb begin
    alarm = state == S_ALARM;
    out_valid = !empty && !alarm;
    pop = out_valid && out_ready;
    push = state == S_RUN && accept && !fail && (!full || pop);
    flush = state_next == S_ALARM;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_byte <= 8'h00;
      ref_byte <= 8'h00;
      run_cnt <= '0;
      match_cnt <= '0;
      win_cnt <= '0;
      warm_cnt <= '0;
    end else if (state == S_ALARM && alarm_clr) begin
      run_cnt <= '0;
      match_cnt <= '0;
      win_cnt <= '0;
      warm_cnt <= '0;
    end else if (accept) begin
      prev_byte <= in_data;
      run_cnt <= run_next;
      match_cnt <= match_next;
      ref_byte <= win_start ? in_data : ref_byte;
      win_cnt <= win_cnt == WW'(APT_WINDOW - 1) ? '0 : win_cnt + WW'(1);
      warm_cnt <= state == S_WARMUP ? warm_cnt + CW'(1) : warm_cnt;
    end
  end
  trng_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (in_data),
    .dout  (out_data),
    .count (fill_level),
    .full  (full),
    .empty (empty)
  );
endmodule
